// File: rtl/sram_1w1r_pipe_model.sv
// sram_1w1r_pipe_model: single-clock 1W/1R SRAM model with lane write masks,
// configurable read latency, optional write-to-read bypass, read-valid strobe,
// post-reset clear sequencer and a saturating collision counter.
module sram_1w1r_pipe_model #(
    parameter int unsigned DATA_WIDTH   = 22,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned RAM_DEPTH    = 1 << ADDR_WIDTH,
    parameter int unsigned WMASK_WIDTH  = 2,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned BYPASS       = 1,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   csb0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   dout1_vld,
    output logic                   init_busy,
    output logic [CNT_WIDTH-1:0]   collision_cnt
);

    localparam int unsigned LANE_W = DATA_WIDTH / WMASK_WIDTH;

    typedef enum logic {INIT, RUN} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]   mem_q [RAM_DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_data_d [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   dout1_q, dout1_d;
    logic                    dout1_vld_q, dout1_vld_d;
    logic [CNT_WIDTH-1:0]    coll_cnt_q, coll_cnt_d;

    logic                    run;
    logic                    wr_in_range, rd_in_range, collision;
    logic [DATA_WIDTH-1:0]   wr_old, wr_merged, rd_word;

    // Port decode: lane merge of the write word and the read word seen this cycle
    always_comb begin
        run         = (state_q == RUN);
        wr_in_range = 32'(addr0) < RAM_DEPTH;
        rd_in_range = 32'(addr1) < RAM_DEPTH;
        collision   = run && !csb0 && !csb1 && (addr0 == addr1);
        wr_old      = wr_in_range ? mem_q[addr0] : '0;
        wr_merged   = wr_old;
        for (int unsigned i = 0; i < WMASK_WIDTH; i++) begin
            if (wmask0[i]) begin
                wr_merged[i*LANE_W +: LANE_W] = din0[i*LANE_W +: LANE_W];
            end
        end
        rd_word = rd_in_range ? mem_q[addr1] : '0;
        // On a collision the addresses match, so wr_merged is built from the same word
        if ((BYPASS != 0) && collision && rd_in_range) begin
            rd_word = wr_merged;
        end
    end

    // Clear sequencer: walk ptr over every word, then hand the array to the ports
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            INIT: begin
                ptr_d = ptr_q + 1'b1;
                if (32'(ptr_q) == RAM_DEPTH - 1) begin
                    state_d = RUN;
                    ptr_d   = '0;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // Single array write port shared by the clear sequencer and the write port
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        if (!run) begin
            mem_we = 1'b1;
        end else if (!csb0 && wr_in_range && (|wmask0)) begin
            mem_we    = 1'b1;
            mem_waddr = addr0;
            mem_wdata = wr_merged;
        end
    end

    // Read pipeline: stage 0 captures the word at the sampling edge, output holds otherwise
    always_comb begin
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            pipe_data_d[i] = pipe_data_q[i];
        end
        pipe_vld_d     = '0;
        pipe_vld_d[0]  = run && !csb1;
        if (run && !csb1) begin
            pipe_data_d[0] = rd_word;
        end
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
        dout1_vld_d = pipe_vld_q[READ_LATENCY-1];
        dout1_d     = pipe_vld_q[READ_LATENCY-1] ? pipe_data_q[READ_LATENCY-1] : dout1_q;
    end

    // Collision counter saturates at all-ones
    always_comb begin
        coll_cnt_d = coll_cnt_q;
        if (collision && (coll_cnt_q != '1)) begin
            coll_cnt_d = coll_cnt_q + 1'b1;
        end
    end

    // Control and read-path registers, asynchronously reset
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= INIT;
            ptr_q       <= '0;
            pipe_vld_q  <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_data_q[i] <= '0;
            end
            dout1_q     <= '0;
            dout1_vld_q <= 1'b0;
            coll_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            pipe_vld_q  <= pipe_vld_d;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_data_q[i] <= pipe_data_d[i];
            end
            dout1_q     <= dout1_d;
            dout1_vld_q <= dout1_vld_d;
            coll_cnt_q  <= coll_cnt_d;
        end
    end

    // Storage array: never reset, cleared only by the sequencer
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign dout1         = dout1_q;
    assign dout1_vld     = dout1_vld_q;
    assign init_busy     = (state_q == INIT);
    assign collision_cnt = coll_cnt_q;

endmodule

// File: tb/tb_sram_1w1r_pipe_model.sv
// Bench for sram_1w1r_pipe_model: two instances share one stimulus stream
// (A: defaults; B: depth 24, latency 2, no bypass, 2-bit counter) and are
// checked every cycle against a queue-based reference plus literal checkpoints.
module tb_sram_1w1r_pipe_model;

    localparam int DW = 22;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          csb0 = 1'b1;
    logic          csb1 = 1'b1;
    logic [1:0]    wmask0 = '0;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;
    logic [DW-1:0] din0 = '0;

    logic [DW-1:0] dout_a, dout_b;
    logic          vld_a, vld_b, busy_a, busy_b;
    logic [7:0]    cnt_a;
    logic [1:0]    cnt_b;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    sram_1w1r_pipe_model #(
        .DATA_WIDTH(22), .ADDR_WIDTH(5), .RAM_DEPTH(32), .WMASK_WIDTH(2),
        .READ_LATENCY(1), .BYPASS(1), .CNT_WIDTH(8)
    ) dut_a (
        .clk(clk), .rstb(rstb), .csb0(csb0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .csb1(csb1), .addr1(addr1), .dout1(dout_a),
        .dout1_vld(vld_a), .init_busy(busy_a), .collision_cnt(cnt_a)
    );

    sram_1w1r_pipe_model #(
        .DATA_WIDTH(22), .ADDR_WIDTH(5), .RAM_DEPTH(24), .WMASK_WIDTH(2),
        .READ_LATENCY(2), .BYPASS(0), .CNT_WIDTH(2)
    ) dut_b (
        .clk(clk), .rstb(rstb), .csb0(csb0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .csb1(csb1), .addr1(addr1), .dout1(dout_b),
        .dout1_vld(vld_b), .init_busy(busy_b), .collision_cnt(cnt_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned m_depth(input int i);
        return (i == 0) ? 32 : 24;
    endfunction
    function automatic int unsigned m_lat(input int i);
        return (i == 0) ? 1 : 2;
    endfunction
    function automatic int unsigned m_cmax(input int i);
        return (i == 0) ? 255 : 3;
    endfunction
    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [1:0] m);
        logic [DW-1:0] r;
        r = old;
        if (m[0]) r[10:0]  = nw[10:0];
        if (m[1]) r[21:11] = nw[21:11];
        return r;
    endfunction

    typedef struct {
        int            inst;
        longint        due;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           m_q[$];
    logic [DW-1:0] m_mem [2][32];
    int unsigned   m_init [2];
    int unsigned   m_cnt  [2];
    logic [DW-1:0] m_dout [2];
    logic          m_vld  [2];
    longint        m_cyc;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_cyc = 0;
            m_q.delete();
            for (int i = 0; i < 2; i++) begin
                m_init[i] = 0;
                m_cnt[i]  = 0;
                m_dout[i] = '0;
                m_vld[i]  = 1'b0;
                for (int a = 0; a < 32; a++) m_mem[i][a] = '0;
            end
        end else begin
            m_cyc++;
            for (int i = 0; i < 2; i++) begin
                logic          coll;
                logic [DW-1:0] rd;
                m_vld[i] = 1'b0;
                foreach (m_q[k]) begin
                    if (m_q[k].inst == i && m_q[k].due == m_cyc) begin
                        m_dout[i] = m_q[k].data;
                        m_vld[i]  = 1'b1;
                    end
                end
                if (m_init[i] < m_depth(i)) begin
                    m_init[i]++;
                end else begin
                    coll = !csb0 && !csb1 && (addr0 == addr1);
                    if (!csb1) begin
                        rd = (32'(addr1) < m_depth(i)) ? m_mem[i][addr1] : '0;
                        if (coll && i == 0 && 32'(addr1) < m_depth(i)) rd = merge(rd, din0, wmask0);
                        m_q.push_back('{i, m_cyc + longint'(m_lat(i)), rd});
                    end
                    if (coll && m_cnt[i] < m_cmax(i)) m_cnt[i]++;
                    if (!csb0 && 32'(addr0) < m_depth(i))
                        m_mem[i][addr0] = merge(m_mem[i][addr0], din0, wmask0);
                end
            end
            for (int k = m_q.size() - 1; k >= 0; k--) begin
                if (m_q[k].due <= m_cyc) m_q.delete(k);
            end
        end
    end

    // Every-cycle comparison against the reference
    always @(negedge clk) begin
        chk("a_dout", 32'(dout_a), 32'(m_dout[0]));
        chk("a_vld",  32'(vld_a),  32'(m_vld[0]));
        chk("a_busy", 32'(busy_a), 32'(m_init[0] < m_depth(0)));
        chk("a_cnt",  32'(cnt_a),  m_cnt[0]);
        chk("b_dout", 32'(dout_b), 32'(m_dout[1]));
        chk("b_vld",  32'(vld_b),  32'(m_vld[1]));
        chk("b_busy", 32'(busy_b), 32'(m_init[1] < m_depth(1)));
        chk("b_cnt",  32'(cnt_b),  m_cnt[1]);
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        csb0 = 1'b1; csb1 = 1'b1; wmask0 = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] m);
        csb0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        csb1 = 1'b0; addr1 = a;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while ((busy_a || busy_b) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("init_done", 32'(busy_a | busy_b), 32'd0);
    endtask

    task automatic count_init(input string name);
        int n;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (!busy_a) break;
        end
        chk(name, n, 32);
    endtask

    initial begin
        int na, nb;
        // Reset state
        #2;
        chk("rst_busy", 32'(busy_a), 32'd1);
        chk("rst_vld",  32'(vld_a),  32'd0);
        chk("rst_dout", 32'(dout_a), 32'd0);
        chk("rst_cnt",  32'(cnt_a),  32'd0);
        @(negedge clk); @(negedge clk);
        rstb = 1'b1;

        // Reset mid-INIT at cycle 10, then a full INIT again
        repeat (10) @(posedge clk);
        #2 rstb = 1'b0;
        #1 chk("midinit_busy", 32'(busy_a), 32'd1);
        chk("midinit_vld", 32'(vld_b), 32'd0);
        @(negedge clk);
        rstb = 1'b1;
        count_init("init_cycles");
        wait_ready();

        // Back-to-back reads of every address
        na = 0; nb = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (vld_a) na++;
            if (vld_b) nb++;
            rd(AW'(i));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (vld_a) na++;
            if (vld_b) nb++;
            idle();
        end
        chk("b2b_pulses_a", na, 32);
        chk("b2b_pulses_b", nb, 32);

        // Masked write
        @(negedge clk); wr(5, 22'h3FFFFF, 2'b11);
        @(negedge clk); wr(5, 22'h000000, 2'b01);
        @(negedge clk); idle(); rd(5);
        @(negedge clk); idle();
        @(negedge clk);
        chk("mask_a", 32'(dout_a), 32'h3FF800);
        chk("mask_a_vld", 32'(vld_a), 32'd1);
        @(negedge clk);
        chk("mask_b", 32'(dout_b), 32'h3FF800);
        chk("mask_b_vld", 32'(vld_b), 32'd1);

        // Collision: bypass vs. old data
        @(negedge clk); wr(7, 22'h155555, 2'b11);
        @(negedge clk); wr(7, 22'h2AAAAA, 2'b11); rd(7);
        @(negedge clk); idle();
        @(negedge clk);
        chk("coll_a", 32'(dout_a), 32'h2AAAAA);
        chk("coll_cnt_a", 32'(cnt_a), 32'd1);
        chk("coll_cnt_b", 32'(cnt_b), 32'd1);
        @(negedge clk);
        chk("coll_b", 32'(dout_b), 32'h155555);

        // Saturation: 5 colliding cycles, zero mask still counts
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); wr(9, 22'h0ABCDE, 2'b00); rd(9);
        end
        @(negedge clk); idle();
        chk("sat_a", 32'(cnt_a), 32'd6);
        chk("sat_b", 32'(cnt_b), 32'd3);

        // Address 28: in range for A, out of range for B
        @(negedge clk); wr(28, 22'h012345, 2'b11);
        @(negedge clk); idle(); rd(28);
        @(negedge clk); idle();
        @(negedge clk);
        chk("oor_a", 32'(dout_a), 32'h012345);
        @(negedge clk);
        chk("oor_b", 32'(dout_b), 32'd0);
        chk("oor_b_vld", 32'(vld_b), 32'd1);

        // Reset during a read
        @(negedge clk); rd(5);
        @(negedge clk); idle();
        @(posedge clk);
        #2 chk("pre_rst_a", 32'(dout_a), 32'h3FF800);
        rstb = 1'b0;
        #1 chk("midrd_dout", 32'(dout_a), 32'd0);
        chk("midrd_vld", 32'(vld_a), 32'd0);
        chk("midrd_cnt", 32'(cnt_b), 32'd0);
        @(negedge clk);
        rstb = 1'b1;
        wait_ready();
        @(negedge clk); rd(5);
        @(negedge clk); idle();
        @(negedge clk);
        chk("cleared_a", 32'(dout_a), 32'd0);
        chk("cleared_a_vld", 32'(vld_a), 32'd1);

        // Mixed traffic with frequent collisions
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            csb0   = ($urandom_range(0, 3) == 0);
            csb1   = ($urandom_range(0, 3) == 0);
            wmask0 = 2'($urandom_range(0, 3));
            din0   = DW'($urandom);
            addr1  = AW'($urandom_range(0, 31));
            addr0  = ($urandom_range(0, 2) == 0) ? addr1 : AW'($urandom_range(0, 31));
        end
        @(negedge clk); idle();
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
